// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - byte-serial command issuer driving the ALU units and returning their result
module alu_cmd_issuer #(
  parameter int width   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic             clock,
  input  logic             rest,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] A,
  output logic [width-1:0] B,
  output logic [3:0]       ALU_FUN,
  output logic [3:0]       unit_enable,
  input  logic [3:0]       unit_flag,
  input  logic [width-1:0] alu_result,
  output logic [width-1:0] res_data,
  output logic [1:0]       res_status,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam int NB = width / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_TIMEOUT  = 2'b01;
  localparam logic [1:0] ST_MISMATCH = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       timer_q, timer_d;
  logic             in_ready_q, in_ready_d;
  logic [width-1:0] a_q, a_d;
  logic [width-1:0] b_q, b_d;
  logic [3:0]       fun_q, fun_d;
  logic [3:0]       en_q, en_d;
  logic [width-1:0] rdata_q, rdata_d;
  logic [1:0]       rstat_q, rstat_d;
  logic             rvalid_q, rvalid_d;

  logic             xfer;
  logic             last_byte;
  logic             done;

  assign xfer      = in_valid & in_ready_q;
  assign last_byte = (cnt_q == CW'(NB - 1));

  // Next-state logic: frame assembly, unit issue, flag/timeout resolution, result handshake
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    a_d      = a_q;
    b_d      = b_q;
    fun_d    = fun_q;
    en_d     = en_q;
    rdata_d  = rdata_q;
    rstat_d  = rstat_q;
    rvalid_d = rvalid_q;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          fun_d   = in_data[3:0];
          cnt_d   = '0;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (xfer) begin
          for (int k = 0; k < NB; k++) begin
            if (cnt_q == CW'(k)) a_d[8*k +: 8] = in_data;
          end
          if (last_byte) begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        if (xfer) begin
          for (int k = 0; k < NB; k++) begin
            if (cnt_q == CW'(k)) b_d[8*k +: 8] = in_data;
          end
          if (last_byte) begin
            cnt_d   = '0;
            state_d = S_ISSUE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        en_d    = 4'b0001 << fun_q[3:2];
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 8'd1;
        // Priority: exact flag match, then a wrong unit answering, then timeout
        if (unit_flag == en_q) begin
          rdata_d = alu_result;
          rstat_d = ST_OK;
          done    = 1'b1;
        end else if (unit_flag != 4'b0000) begin
          rdata_d = '0;
          rstat_d = ST_MISMATCH;
          done    = 1'b1;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          rdata_d = '0;
          rstat_d = ST_TIMEOUT;
          done    = 1'b1;
        end
        if (done) begin
          en_d     = 4'b0000;
          rvalid_d = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rvalid_q && res_ready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered ready follows the state we are entering, so it is exact on the next cycle
    in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
  end

  // State and output registers; reset clears everything, dropping unit_enable asynchronously
  always_ff @(posedge clock or negedge rest) begin
    if (!rest) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      timer_q    <= '0;
      in_ready_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      en_q       <= '0;
      rdata_q    <= '0;
      rstat_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      in_ready_q <= in_ready_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      en_q       <= en_d;
      rdata_q    <= rdata_d;
      rstat_q    <= rstat_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign A           = a_q;
  assign B           = b_q;
  assign ALU_FUN     = fun_q;
  assign unit_enable = en_q;
  assign res_data    = rdata_q;
  assign res_status  = rstat_q;
  assign res_valid   = rvalid_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - directed self-checking bench for alu_cmd_issuer
module tb_alu_cmd_issuer;

  localparam int W  = 16;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          rest;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [3:0]    ALU_FUN;
  logic [3:0]    unit_enable;
  logic [3:0]    unit_flag;
  logic [W-1:0]  alu_result;
  logic [W-1:0]  res_data;
  logic [1:0]    res_status;
  logic          res_valid;
  logic          res_ready;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            mode;

  alu_cmd_issuer #(.width(W), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .rest        (rest),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .ALU_FUN     (ALU_FUN),
    .unit_enable (unit_enable),
    .unit_flag   (unit_flag),
    .alu_result  (alu_result),
    .res_data    (res_data),
    .res_status  (res_status),
    .res_valid   (res_valid),
    .res_ready   (res_ready)
  );

  always #5 clock = ~clock;

  // Unit stand-in: mode 1 echoes the enable one edge later, mode 2 answers as the arith unit, mode 0 stays silent
  always @(posedge clock or negedge rest) begin
    if (!rest) unit_flag <= 4'b0000;
    else if (mode == 1) unit_flag <= unit_enable;
    else if (mode == 2) unit_flag <= (unit_enable != 4'b0000) ? 4'b0001 : 4'b0000;
    else unit_flag <= 4'b0000;
  end

  // Units drive zero unless their flag is up: arith adds, logic ANDs
  always_comb begin
    alu_result = '0;
    if (unit_flag[0]) alu_result = alu_result | (A + B);
    if (unit_flag[1]) alu_result = alu_result | (A & B);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    send_byte(op);
    for (int k = 0; k < W/8; k++) send_byte(a[8*k +: 8]);
    for (int k = 0; k < W/8; k++) send_byte(b[8*k +: 8]);
  endtask

  task automatic wait_result();
    int n = 0;
    while (!res_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    check("res_valid_cleared", 32'(res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int n;
    logic [7:0] gap_bytes [5];
    gap_bytes[0] = 8'h00; gap_bytes[1] = 8'h34; gap_bytes[2] = 8'h12;
    gap_bytes[3] = 8'hCD; gap_bytes[4] = 8'hAB;

    mode      = 0;
    rest      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    res_ready = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_in_ready",   32'(in_ready),    32'd0);
    check("rst_A",          32'(A),           32'd0);
    check("rst_B",          32'(B),           32'd0);
    check("rst_fun",        32'(ALU_FUN),     32'd0);
    check("rst_enable",     32'(unit_enable), 32'd0);
    check("rst_res_data",   32'(res_data),    32'd0);
    check("rst_res_status", 32'(res_status),  32'd0);
    check("rst_res_valid",  32'(res_valid),   32'd0);
    rest = 1'b1;
    @(negedge clock);
    check("idle_ready", 32'(in_ready), 32'd1);

    // Logic AND with exact latency
    mode = 1;
    send_frame(8'h04, 16'hF00F, 16'h00FF);
    check("and_ready_low", 32'(in_ready), 32'd0);
    @(negedge clock);
    check("and_enable", 32'(unit_enable), 32'h2);
    check("and_A",      32'(A),           32'hF00F);
    check("and_B",      32'(B),           32'h00FF);
    check("and_fun",    32'(ALU_FUN),     32'h4);
    @(negedge clock);
    check("and_valid_early", 32'(res_valid), 32'd0);
    @(negedge clock);
    check("and_valid",  32'(res_valid),   32'd1);
    check("and_data",   32'(res_data),    32'h000F);
    check("and_status", 32'(res_status),  32'd0);
    check("and_en_clr", 32'(unit_enable), 32'd0);
    handshake();

    // Timeout: enable held exactly TIMEOUT cycles
    mode = 0;
    send_frame(8'h08, 16'h0001, 16'h0002);
    n = 0;
    while (unit_enable == 4'h0 && n < 10) begin
      @(negedge clock);
      n++;
    end
    cnt = 0;
    while (unit_enable == 4'h4 && cnt < 50) begin
      cnt++;
      @(negedge clock);
    end
    check("to_en_cycles", 32'(cnt),         32'd8);
    check("to_valid",     32'(res_valid),   32'd1);
    check("to_status",    32'(res_status),  32'd1);
    check("to_data",      32'(res_data),    32'd0);
    check("to_en_clr",    32'(unit_enable), 32'd0);
    handshake();

    // Mismatch: shift unit enabled, arith flag answers
    mode = 2;
    send_frame(8'h0C, 16'h1111, 16'h2222);
    @(negedge clock);
    check("mm_enable", 32'(unit_enable), 32'h8);
    wait_result();
    check("mm_status", 32'(res_status), 32'd2);
    check("mm_data",   32'(res_data),   32'd0);
    handshake();

    // Backpressure in RESP with a byte waiting upstream
    mode = 1;
    send_frame(8'h04, 16'h1111, 16'h0F0F);
    wait_result();
    in_data  = 8'h05;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_ready_low", 32'(in_ready), 32'd0);
      check("bp_data_hold", 32'(res_data), 32'h0101);
    end
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    check("bp_valid_clr", 32'(res_valid), 32'd0);
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    send_byte(8'h05);
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hFF); send_byte(8'h00);
    wait_result();
    check("bp_fun",  32'(ALU_FUN),  32'h5);
    check("bp_data", 32'(res_data), 32'h0034);
    handshake();

    // Gapped input: one idle cycle after every byte
    for (int i = 0; i < 5; i++) begin
      send_byte(gap_bytes[i]);
      if (i < 4) begin
        @(negedge clock);
        check("gap_no_issue", 32'(unit_enable), 32'd0);
      end
    end
    wait_result();
    check("gap_A",    32'(A),        32'h1234);
    check("gap_B",    32'(B),        32'hABCD);
    check("gap_data", 32'(res_data), 32'hBE01);
    handshake();

    // Asynchronous reset while waiting on the logic unit
    mode = 0;
    send_frame(8'h04, 16'hF00F, 16'h00FF);
    @(negedge clock);
    check("ar_enable_before", 32'(unit_enable), 32'h2);
    #2 rest = 1'b0;
    #1;
    check("ar_enable",   32'(unit_enable), 32'd0);
    check("ar_A",        32'(A),           32'd0);
    check("ar_B",        32'(B),           32'd0);
    check("ar_fun",      32'(ALU_FUN),     32'd0);
    check("ar_in_ready", 32'(in_ready),    32'd0);
    check("ar_valid",    32'(res_valid),   32'd0);
    @(negedge clock);
    rest = 1'b1;
    @(negedge clock);
    mode = 1;
    send_frame(8'h04, 16'hF00F, 16'h00FF);
    wait_result();
    check("ar_fresh_data",   32'(res_data),   32'h000F);
    check("ar_fresh_status", 32'(res_status), 32'd0);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
